sensor_bus_arbiter: RTL and testbench
=====================================

SENSOR_BUS_ARBITER -- requirements
Module: sensor_bus_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, on ports clk and rst.
REQ-002 Parameter MAX_HOLD SHALL default to 200 and set the maximum number of cycles a grant is held; legal range is 2..255.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  asynchronous reset, active high.
REQ-005 req  input  4  per-group request; bit i = walker group i+1.
REQ-006 done  input  4  per-group release strobe; bit i = walker group i+1.
REQ-007 sensor  input  4  shared sensor bus.
REQ-008 mov_bus  input  16  packed movement codes; bits [4i+3:4i] = group i+1.
REQ-009 grant  output  4  one-hot grant, registered.
REQ-010 sensor_out  output  16  sensor routed to the granted group's slot [4i+3:4i].
REQ-011 movement_sel  output  4  movement code of the granted group.
REQ-012 busy  output  1  high while any grant is asserted.
REQ-013 timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-014 The FSM SHALL have the states IDLE, GRANT and RELEASE, encoded in 2 bits; unused codes SHALL return to IDLE.
- IDLE: if req != 0, go to GRANT.
- GRANT: go to RELEASE on done[g], on req[g]=0, or on watchdog expiry.
- RELEASE: if req != 0, go to GRANT; otherwise go to IDLE.
REQ-015 Selection SHALL be round-robin: the first set req bit at or after ptr, searched upward and wrapping from 3 to 0.
REQ-016 ptr SHALL update to (g+1) mod 4 on entry to RELEASE.
REQ-017 grant SHALL rise on the first clock edge that samples req != 0 in IDLE or RELEASE, giving one cycle of latency.
REQ-018 grant SHALL be 0 throughout RELEASE, giving exactly one dead cycle between consecutive grants.
REQ-019 grant SHALL never have more than one bit set.
REQ-020 done and req-drop from non-granted groups SHALL be ignored.
REQ-021 movement_sel SHALL equal mov_bus[4g+3:4g] while in GRANT and 4'b0000 otherwise; it is combinational from the state and mov_bus.
REQ-022 sensor_out SHALL carry sensor in slot g while in GRANT, with all other slots 0; outside GRANT sensor_out SHALL be 0.
REQ-023 busy SHALL equal |grant.
REQ-024 An 8-bit hold counter SHALL behave as follows:
- clears on entry to GRANT;
- increments each cycle spent in GRANT;
- saturates at 255.
REQ-025 When the counter equals MAX_HOLD-1 with done[g]=0 and req[g]=1, the FSM SHALL go to RELEASE and timeout SHALL pulse high for that RELEASE cycle.
REQ-026 If done[g] and expiry occur on the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-027 A timed-out group SHALL re-enter arbitration normally; ptr has already advanced past it.

Reset
REQ-028 rst SHALL immediately force the following, independent of clk:
- state = IDLE;
- ptr = 0;
- counter = 0;
- grant = 0, timeout = 0.
REQ-029 Because movement_sel and sensor_out are gated by the state, they SHALL read 0 during reset.
REQ-030 After rst deasserts, the first grant SHALL follow the REQ-017 timing, with priority starting at group 1.
REQ-031 Reset asserted mid-grant SHALL drop grant with no timeout pulse.

Configuration
REQ-032 With macro SENSOR_BUS_ARB_TIMEOUT_EN defined, the watchdog of REQ-024..REQ-027 SHALL be compiled in.
REQ-033 Without SENSOR_BUS_ARB_TIMEOUT_EN:
- the counter SHALL be omitted;
- grants SHALL end only on done[g] or req[g]=0;
- timeout SHALL be tied to 0.

Verification
REQ-034 Basic grant: after reset, req=0010 -> grant=0010 one edge later; with mov_bus[7:4]=1010, movement_sel=1010; sensor=0101 -> sensor_out[7:4]=0101 and all other bits 0.
REQ-035 Round-robin: req=1111 held, each group pulses done one cycle after its grant -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-036 Watchdog (macro defined, MAX_HOLD=4): req=0001 with done=0 -> grant high 4 cycles, then timeout=1 for one cycle with grant=0000.
REQ-037 Watchdog tie: as REQ-036, with done[0] asserted on the 4th grant cycle -> timeout stays 0.
REQ-038 Reset mid-grant: grant=0100 when rst=1 -> grant=0000 and movement_sel=0000 immediately; after release, req=1100 -> grant=0100 (ptr=0, so group 3 is first at or after 0).
REQ-039 Macro undefined: req=0001 held 300 cycles -> grant stays 0001 and timeout stays 0.

Source files
------------

// File: rtl/sensor_bus_arbiter.sv
// sensor_bus_arbiter
//   Round-robin arbiter that hands a shared sensor bus to one of four walker
//   groups at a time. The granted group's sensor slot and movement code are
//   routed out while the grant is held.
//
//   Optional feature macro: SENSOR_BUS_ARB_TIMEOUT_EN
//     When defined, a hold-counter watchdog revokes any grant held for
//     MAX_HOLD cycles and pulses timeout. When undefined, there is no counter,
//     grants end only on done/req-drop, and timeout is tied low.
//
//   Handshake: a group raises req[i] and holds it while it wants the bus; the
//   grant is released when that group strobes done[i] or drops req[i].
//   Strobes and req-drops from non-granted groups have no effect.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous reset, active high
//     req[3:0]     per-group request (bit i = group i+1)
//     done[3:0]    per-group release strobe
//     sensor[3:0]  shared sensor bus
//     mov_bus[15:0] packed movement codes, [4i+3:4i] = group i+1
//     grant[3:0]   registered one-hot grant
//     sensor_out[15:0] sensor placed in the granted group's slot
//     movement_sel[3:0] movement code of the granted group
//     busy         high while any grant is asserted
//     timeout      one-cycle pulse when the watchdog revokes a grant
module sensor_bus_arbiter #(
   parameter int MAX_HOLD = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [3:0]  done,
   input  logic [3:0]  sensor,
   input  logic [15:0] mov_bus,
   output logic [3:0]  grant,
   output logic [15:0] sensor_out,
   output logic [3:0]  movement_sel,
   output logic        busy,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t      r_state;
   logic [1:0]  r_ptr;
   logic [1:0]  r_gidx;
   logic [3:0]  r_grant;

   logic [1:0]  w_pick;
   logic        w_any_req;
   logic        w_done_g;
   logic        w_req_g;
   logic        w_expire;
   logic        w_end_grant;
   logic [15:0] w_sensor_out;

   // First set request at or after p, wrapping 3 -> 0. Scanning offsets from
   // largest to smallest lets the smallest offset win.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      pick = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   assign w_pick      = pick(req, r_ptr);
   assign w_any_req   = |req;
   assign w_done_g    = done[r_gidx];
   assign w_req_g     = req[r_gidx];
   assign w_end_grant = (r_state == GRANT) && (w_done_g || !w_req_g || w_expire);

`ifdef SENSOR_BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] r_hold;
   logic       r_timeout;
   logic       w_enter_grant;

   // Expiry only counts when done did not arrive the same cycle (done wins)
   // and the group still requests (a plain req-drop is not a timeout).
   assign w_expire      = (r_state == GRANT) && (r_hold == HOLD_LAST) && !w_done_g && w_req_g;
   assign w_enter_grant = ((r_state == IDLE) || (r_state == RELEASE)) && w_any_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold    <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_enter_grant)
            r_hold <= 8'd0;
         else if ((r_state == GRANT) && (r_hold != 8'hFF))
            r_hold <= r_hold + 8'd1;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_expire = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= 2'd0;
         r_gidx  <= 2'd0;
         r_grant <= 4'b0000;
      end else begin
         case (r_state)
            IDLE, RELEASE: begin
               if (w_any_req) begin
                  r_state <= GRANT;
                  r_gidx  <= w_pick;
                  r_grant <= 4'b0001 << w_pick;
               end else begin
                  r_state <= IDLE;
                  r_grant <= 4'b0000;
               end
            end
            GRANT: begin
               if (w_end_grant) begin
                  r_state <= RELEASE;
                  r_grant <= 4'b0000;
                  r_ptr   <= r_gidx + 2'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 4'b0000;
            end
         endcase
      end
   end

   always_comb begin
      w_sensor_out = 16'h0000;
      if (r_state == GRANT)
         w_sensor_out[{r_gidx, 2'b00} +: 4] = sensor;
   end

   assign grant        = r_grant;
   assign busy         = |r_grant;
   assign sensor_out   = w_sensor_out;
   assign movement_sel = (r_state == GRANT) ? mov_bus[{r_gidx, 2'b00} +: 4] : 4'b0000;

endmodule

// File: tb/tb_sensor_bus_arbiter.sv
module tb_sensor_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [3:0]  done = 4'b0000;
   logic [3:0]  sensor = 4'b0000;
   logic [15:0] mov_bus = 16'h0000;
   logic [3:0]  grant;
   logic [15:0] sensor_out;
   logic [3:0]  movement_sel;
   logic        busy;
   logic        timeout;

   int n_cmp = 0;
   int n_err = 0;

   // {timeout, grant} expected per observed cycle
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

`ifdef SENSOR_BUS_ARB_TIMEOUT_EN
   sensor_bus_arbiter #(.MAX_HOLD(4)) dut (
`else
   sensor_bus_arbiter dut (
`endif
      .clk(clk), .rst(rst), .req(req), .done(done), .sensor(sensor),
      .mov_bus(mov_bus), .grant(grant), .sensor_out(sensor_out),
      .movement_sel(movement_sel), .busy(busy), .timeout(timeout)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 4'b0000; done = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (movement_sel !== 4'b0000) begin n_err++; $display("FAIL reset_mov: got %b want 0000", movement_sel); end
      n_cmp++; if (sensor_out !== 16'h0000) begin n_err++; $display("FAIL reset_sensor_out: got %h want 0000", sensor_out); end
   endtask

   task automatic test_basic_grant();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      req = 4'b0010; mov_bus = 16'h00A0; sensor = 4'b0101;
      #1;
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL basic_pre_edge: got %b want 0000", grant); end
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL basic_grant: got %b want 0010", grant); end
      n_cmp++; if (movement_sel !== 4'b1010) begin n_err++; $display("FAIL basic_mov: got %b want 1010", movement_sel); end
      n_cmp++; if (sensor_out !== 16'h0050) begin n_err++; $display("FAIL basic_sensor_out: got %h want 0050", sensor_out); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
      req = 4'b0000;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL basic_release: got %b want 0000", grant); end
      n_cmp++; if (sensor_out !== 16'h0000) begin n_err++; $display("FAIL basic_release_sensor: got %h want 0000", sensor_out); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL basic_release_timeout: got %b want 0", timeout); end
   endtask

   task automatic test_round_robin();
      logic [4:0] exp;
      do_reset();
      exp_q = {5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100,
               5'b00000, 5'b01000, 5'b00000, 5'b00001};
      mov_bus = 16'h4321;
      req = 4'b1111;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_cmp++;
         if ({timeout, grant} !== exp) begin
            n_err++;
            $display("FAIL rr_cycle%0d: got t=%b g=%b want t=%b g=%b", c, timeout, grant, exp[4], exp[3:0]);
         end
         done = grant;
      end
      req = 4'b0000; done = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_ignore_others();
      do_reset();
      req = 4'b0011;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL ign_grant: got %b want 0001", grant); end
      req = 4'b0001; done = 4'b1110;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL ign_hold1: got %b want 0001", grant); end
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL ign_hold2: got %b want 0001", grant); end
      req = 4'b0000; done = 4'b0000;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL ign_drop: got %b want 0000", grant); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL ign_drop_timeout: got %b want 0", timeout); end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      mov_bus = 16'h0B00;
      req = 4'b0100;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL rmid_grant: got %b want 0100", grant); end
      n_cmp++; if (movement_sel !== 4'b1011) begin n_err++; $display("FAIL rmid_mov: got %b want 1011", movement_sel); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rmid_async_grant: got %b want 0000", grant); end
      n_cmp++; if (movement_sel !== 4'b0000) begin n_err++; $display("FAIL rmid_async_mov: got %b want 0000", movement_sel); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rmid_async_timeout: got %b want 0", timeout); end
      @(negedge clk);
      rst = 1'b0; req = 4'b1100;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL rmid_after: got %b want 0100", grant); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rmid_after_timeout: got %b want 0", timeout); end
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

`ifdef SENSOR_BUS_ARB_TIMEOUT_EN
   task automatic test_watchdog();
      logic [4:0] exp;
      do_reset();
      exp_q = {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b10000, 5'b00001};
      req = 4'b0001;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_cmp++;
         if ({timeout, grant} !== exp) begin
            n_err++;
            $display("FAIL wd_cycle%0d: got t=%b g=%b want t=%b g=%b", c, timeout, grant, exp[4], exp[3:0]);
         end
      end
      req = 4'b0000;
      @(negedge clk);
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_drop_timeout: got %b want 0", timeout); end
      @(negedge clk);
   endtask

   task automatic test_watchdog_tie();
      logic [4:0] exp;
      do_reset();
      exp_q = {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
      req = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_cmp++;
         if ({timeout, grant} !== exp) begin
            n_err++;
            $display("FAIL tie_cycle%0d: got t=%b g=%b want t=%b g=%b", c, timeout, grant, exp[4], exp[3:0]);
         end
         done = (c == 3) ? 4'b0001 : 4'b0000;
      end
      req = 4'b0000; done = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask
`else
   task automatic test_no_watchdog();
      do_reset();
      req = 4'b0001;
      @(negedge clk);
      for (int c = 0; c < 300; c++) begin
         n_cmp++;
         if ({timeout, grant} !== 5'b00001) begin
            n_err++;
            $display("FAIL nowd_cycle%0d: got t=%b g=%b want t=0 g=0001", c, timeout, grant);
         end
         @(negedge clk);
      end
      req = 4'b0000;
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL nowd_drop: got %b want 0000", grant); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_grant();
      test_round_robin();
      test_ignore_others();
      test_reset_mid_grant();
`ifdef SENSOR_BUS_ARB_TIMEOUT_EN
      test_watchdog();
      test_watchdog_tie();
`else
      test_no_watchdog();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
